// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame width and
// baud-divider helpers.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  function automatic int uart_div_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: counts 0..DIV-1 while enabled and pulses tick_o on the last count.
// clr_i holds the count at zero so the sampling phase restarts from the detected edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = uart_div_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver (LSB-first 8N1) with a valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD) and the parity_err pulse.
//
// state  | meaning
// IDLE   | waiting for a low line (only after the line has been seen high)
// START  | counting to mid start bit; a high sample there is a rejected glitch
// DATA   | sampling data bits at mid-bit, LSB first
// PARITY | sampling the parity bit (parity build only)
// STOP   | mid-stop decision: deliver byte or flag a framing error
// BREAK  | line held low after a framing error; wait for it to go high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      overrun_err
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_core: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
  end

  uart_state_e               state_q, state_d;
  logic [1:0]                sync_q, prime_q;
  logic                      armed_q, armed_d;
  logic [SW-1:0]             scnt_q, scnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                      valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                      rxs, tick, samp, good;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d, perr_q, perr_d;
`endif

  // prime_q marks when the synchronizer holds real line samples rather than reset values
  assign rxs     = sync_q[1];
  assign armed_d = armed_q | (prime_q[1] & rxs);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}),
    .clr_i (state_q == ST_IDLE),
    .tick_o(tick)
  );

  assign samp = tick && (scnt_q == FULL_LAST);

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    good    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (tick && (state_q inside {ST_DATA, ST_PARITY, ST_STOP})) begin
      scnt_d = samp ? '0 : scnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        scnt_d = '0;
        if (armed_q && !rxs) state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (scnt_q == HALF_LAST) begin
          scnt_d  = '0;
          bit_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_DATA: if (samp) begin
        shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_LAST) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (samp) begin
        par_bad_d = ((^shift_q) ^ rxs) != PARITY_ODD;
        state_d   = ST_STOP;
      end
`endif
      ST_STOP: if (samp) begin
        state_d = ST_IDLE;
        if (!rxs) begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
`ifdef UART_RX_PARITY_EN
        else if (par_bad_q) perr_d = 1'b1;
`endif
        else good = 1'b1;
      end
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A byte completing on the same edge as an accept replaces the accepted one
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (good) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b11;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
      scnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], uart_rx};
      prime_q <= {prime_q[0], 1'b1};
      armed_q <= armed_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule
